uart_tx_fifo_feeder: RTL and testbench

//  Byte buffer and handshake stage directly upstream of uart_tx.
//  - Game/debug logic pushes bytes at arbitrary rate into a FIFO.
//  - Block pops one byte at a time, drives din with a one-cycle tx_start pulse, then waits for tx_done_tick.
//  - Decouples bursty producers from the serial line rate.

---
 rtl/uart_tx_fifo_feeder.sv | 106 ++++++++++
 tb/tb_uart_tx_fifo_feeder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_feeder.sv
// uart_tx_fifo_feeder: byte FIFO that pops one byte at a time into uart_tx with a start pulse and done handshake.
// Optional UART_TX_FEEDER_OVF_EN adds a sticky overflow flag (ovf) with a clear input (ovf_clr).
module uart_tx_fifo_feeder #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              tx_start,
    output logic [DBIT-1:0]   tx_din,
    input  logic              tx_done_tick,
    output logic              busy
`ifdef UART_TX_FEEDER_OVF_EN
    ,
    output logic              ovf,
    input  logic              ovf_clr
`endif
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(2**ADDR_W);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t            state, state_next;
    logic [DBIT-1:0]   ram [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_next;
    logic              push, pop;

    assign push = wr_en && !full;
    assign pop  = (state == IDLE) && !empty;
    assign count_next = count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};

    // storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push)
            ram[wr_ptr] <= wr_data;
    end

    // pointers, occupancy and registered flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count_next;
            full   <= (count_next == FULL_CNT);
            empty  <= (count_next == '0);
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // next state; a done pulse only matters while waiting on uart_tx
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = !empty ? START : IDLE;
            START:   state_next = WAIT;
            WAIT:    state_next = tx_done_tick ? IDLE : WAIT;
            default: state_next = IDLE;
        endcase
    end

    // registered handshake outputs; tx_din only changes on a pop
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_start <= 1'b0;
            busy     <= 1'b0;
            tx_din   <= '0;
        end else begin
            tx_start <= (state == START);
            busy     <= (state_next != IDLE);
            if (pop)
                tx_din <= ram[rd_ptr];
        end
    end

`ifdef UART_TX_FEEDER_OVF_EN
    // sticky overflow; a dropped push wins over a coincident clear
    always_ff @(posedge clk) begin
        if (reset)
            ovf <= 1'b0;
        else if (wr_en && full)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// tb_uart_tx_fifo_feeder: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_uart_tx_fifo_feeder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, tx_start, busy;
    logic [4:0] count;
    logic [7:0] tx_din;
    logic       tx_done_tick = 1'b0;
`ifdef UART_TX_FEEDER_OVF_EN
    logic       ovf;
    logic       ovf_clr = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_feeder #(.DBIT(8), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count),
        .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tx_done_tick), .busy(busy)
`ifdef UART_TX_FEEDER_OVF_EN
        , .ovf(ovf), .ovf_clr(ovf_clr)
`endif
    );

    // reference model: queue of waiting bytes plus a transmit phase tracker
    int         mq[$];
    bit         m_idle = 1'b1;
    int         m_since = 0;
    logic [7:0] m_din = 8'h00;
    bit         m_start = 1'b0;
    bit         m_ovf = 1'b0;
    int         sent[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic w, input logic [7:0] d, input logic dn, input logic r, input logic clr);
        int pre;
        if (r) begin
            mq.delete();
            m_idle = 1'b1; m_since = 0; m_din = 8'h00; m_start = 1'b0; m_ovf = 1'b0;
        end else begin
            pre = mq.size();
            m_start = 1'b0;
            if (w && pre == 16) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (m_idle && pre > 0) begin
                m_din = 8'(mq.pop_front());
                m_idle = 1'b0;
                m_since = 0;
            end else if (!m_idle) begin
                if (m_since >= 1 && dn) m_idle = 1'b1;
                else begin
                    m_since++;
                    m_start = (m_since == 1);
                end
            end
            if (w && pre < 16) mq.push_back(int'(d));
        end
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic dn, input logic r, input logic clr = 1'b0);
        wr_en = w; wr_data = d; tx_done_tick = dn; reset = r;
`ifdef UART_TX_FEEDER_OVF_EN
        ovf_clr = clr;
`endif
        @(posedge clk);
        model(w, d, dn, r, clr);
        #1;
        chk("count", 32'(count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == 16));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("tx_start", 32'(tx_start), 32'(m_start));
        chk("busy", 32'(busy), 32'(!m_idle));
        chk("tx_din", 32'(tx_din), 32'(m_din));
`ifdef UART_TX_FEEDER_OVF_EN
        chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
        if (tx_start) sent.push_back(int'(tx_din));
    endtask

    task automatic idle_step();
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            idle_step();
            idle_step();
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       dn;
        logic       rst;
        logic [4:0] c;
        logic       e, f, s, b;
        logic [7:0] din;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int idx;
        int exp_q[$];
        bit w;
        logic [7:0] d;

        // single byte: push A5, pop next edge, start pulse the edge after, then done
        tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].wr, tbl[i].d, tbl[i].dn, tbl[i].rst);
            chk($sformatf("t1_count[%0d]", i), 32'(count), 32'(tbl[i].c));
            chk($sformatf("t1_empty[%0d]", i), 32'(empty), 32'(tbl[i].e));
            chk($sformatf("t1_full[%0d]", i), 32'(full), 32'(tbl[i].f));
            chk($sformatf("t1_start[%0d]", i), 32'(tx_start), 32'(tbl[i].s));
            chk($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(tbl[i].b));
            chk($sformatf("t1_din[%0d]", i), 32'(tx_din), 32'(tbl[i].din));
        end

        // 16 pushes without done: one byte leaves for the line, so 15 remain; FF fills, EE is dropped
        step(1'b0, 8'h00, 1'b0, 1'b1);
        sent.delete();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("t2_count15", 32'(count), 32'd15);
        chk("t2_notfull", 32'(full), 32'd0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("t2_full", 32'(full), 32'd1);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("t2_drop_count", 32'(count), 32'd16);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        drain(16);
        chk("t2_sent_n", 32'(sent.size()), 32'd17);
        for (int i = 0; i < 17 && i < sent.size(); i++)
            chk($sformatf("t2_order[%0d]", i), 32'(sent[i]), (i < 16) ? 32'(i) : 32'hFF);

        // simultaneous push and pop at count 5
        step(1'b0, 8'h00, 1'b0, 1'b1);
        sent.delete();
        step(1'b1, 8'h10, 1'b0, 1'b0);
        idle_step();
        idle_step();
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        chk("t3_count5", 32'(count), 32'd5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h16, 1'b0, 1'b0);
        chk("t3_same", 32'(count), 32'd5);
        chk("t3_busy", 32'(busy), 32'd1);
        idle_step();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        drain(5);
        chk("t3_sent_n", 32'(sent.size()), 32'd7);
        for (int i = 0; i < 7 && i < sent.size(); i++)
            chk($sformatf("t3_order[%0d]", i), 32'(sent[i]), 32'(8'h10 + i));

        // wrap: 40 random bytes through the 16-deep FIFO with done offered every cycle
        step(1'b0, 8'h00, 1'b0, 1'b1);
        sent.delete();
        idx = 0;
        for (int k = 0; k < 400 && !(idx == 40 && mq.size() == 0 && m_idle); k++) begin
            w = (idx < 40) && (mq.size() < 16);
            d = 8'($urandom);
            if (w) begin exp_q.push_back(int'(d)); idx++; end
            step(w, d, 1'b1, 1'b0);
        end
        chk("t4_finished", 32'(idx == 40 && mq.size() == 0 && m_idle), 32'd1);
        chk("t4_sent_n", 32'(sent.size()), 32'd40);
        for (int i = 0; i < 40 && i < sent.size() && i < exp_q.size(); i++)
            chk($sformatf("t4_order[%0d]", i), 32'(sent[i]), 32'(exp_q[i]));

        // reset during WAIT with three bytes queued
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h31, 1'b0, 1'b0);
        idle_step();
        idle_step();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        chk("t5_pre_count", 32'(count), 32'd3);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_start", 32'(tx_start), 32'd0);
        idle_step();
        chk("t5_stays_idle", 32'(busy), 32'd0);

`ifdef UART_TX_FEEDER_OVF_EN
        // overflow flag: set on dropped push, cleared, and set winning over clear
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("t6_full", 32'(full), 32'd1);
        chk("t6_ovf0", 32'(ovf), 32'd0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("t6_ovf_set", 32'(ovf), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("t6_ovf_clr", 32'(ovf), 32'd0);
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
        chk("t6_set_wins", 32'(ovf), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
`endif

        // random traffic with occasional reset
        for (int k = 0; k < 600; k++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 7) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
